fpu_seq: RTL and testbench
==========================

Name: fpu_seq

Overview:
- Parametrised, sequential successor to the team's combinational FPU.
- Performs add, sub, mul and div on IEEE-754-style operands of configurable exponent and mantissa width, using a valid/ready handshake on input and output.
- Add, sub and mul finish in fixed latency; div uses a shared radix-2 restoring iterative datapath.
- Sits between the issue stage and writeback; only one operation is in flight at a time.

Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored mantissa width (≥4); W = 1+EXP_W+MAN_W.
- DIV_ITER, MAN_W+2, quotient bits generated by the divider, one per cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an operation.
- opd1  in  W  first operand.
- opd2  in  W  second operand.
- op  in  2  00 add, 01 sub, 10 mul, 11 div (opd1/opd2).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- res  out  W  result.
- exp_overflow  out  1  result exponent ≥ all-ones, or divide by nonzero-finite/zero.
- exp_underflow  out  1  nonzero exact result below min normal; flushed to zero.
- nan  out  1  result is NaN.
- zero  out  1  result is ±0.

Behaviour:
- Reset: all outputs 0 except in_ready=1; FSM→IDLE; div counter 0. Asserting rst_n low mid-operation aborts it immediately with no output.
- FSM states: IDLE, EXEC, DIV, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE→EXEC on in_valid&&in_ready; opd1, opd2 and op are registered at that edge. Inputs are ignored in all other states.
- EXEC (1 cycle):
  - Unpack both operands. Denormal inputs are treated as ±0.
  - Special cases resolve here and go to DONE.
  - Add/sub/mul compute here and go to DONE.
  - Non-special div loads the divider and goes to DIV.
- DIV: one quotient bit per cycle; counter counts DIV_ITER cycles, then normalise/pack → DONE.
- DONE: hold res/flags stable until out_ready. On out_valid&&out_ready → IDLE (in_ready=1 the next cycle; no same-cycle re-accept).
- Latency from accept edge to out_valid: 2 edges for add/sub/mul and all specials; 2+DIV_ITER edges for div (25+2=27 at defaults). Throughput is one op per latency+1 cycles minimum.
- Rounding: truncate toward zero, no guard rounding. Mantissa product is 2·(MAN_W+1) bits; align/shift is truncating.
- Sub: invert sign of opd2, then add. Exact cancellation gives +0.
- Canonical NaN: sign 0, exponent all-ones, mantissa MSB 1, remaining bits 0.
- Specials, in priority order:
  - Any NaN input → canonical NaN, nan=1.
  - inf−inf (effective), 0×inf, 0/0, inf/inf → canonical NaN, nan=1.
  - x/0 with x≠0 → signed inf, exp_overflow=1.
  - Inf operand otherwise → signed inf, no flags.
  - 0 operand for mul, or 0 dividend → signed 0, zero=1.
  - x/inf → signed 0, zero=1.
- Overflow: biased exponent ≥ 2^EXP_W−1 after normalise → signed inf, exp_overflow=1.
- Underflow: biased exponent ≤0 with nonzero mantissa → signed 0, exp_underflow=1, zero=1. This applies to add, sub, mul and div.
- Sign of a zero result: XOR of operand signs for mul/div; for add, +0 unless both operands are −0.
- Flags are mutually consistent: nan excludes zero and overflow.

Test Plan:
- Reset, then add 0x3FC00000 + 0x40100000 → out_valid 2 edges after accept; res 0x40700000; all flags 0.
- Mul 0x40400000 × 0x40000000 with out_ready held low 5 cycles → res 0x40C00000 held stable, in_ready=0 throughout; in_ready=1 the cycle after the handshake.
- Div 0x3F800000 / 0x40400000 → res 0x3EAAAAAA (truncated) after 27 edges. Then 0x3F800000 / 0x00000000 → 0x7F800000, exp_overflow=1. Then 0/0 → 0x7FC00000, nan=1.
- Mul 0x7F000000 × 0x7F000000 → 0x7F800000, exp_overflow=1. Mul 0x00800000 × 0x00800000 → 0x00000000, exp_underflow=1, zero=1.
- Sub 0x3F800000 − 0x3F800000 → 0x00000000, zero=1. Sub 0x00800000 − 0x00C00000 → 0x80000000, exp_underflow=1, zero=1.
- Pull rst_n low at DIV cycle 10 → outputs cleared asynchronously, in_ready=1 after release, no stale out_valid. Repeat add/div with EXP_W=5, MAN_W=10: 0x3C00 / 0x4000 → 0x3800.

Source files
------------

// File: rtl/fpu_seq.sv
// fpu_seq: sequential add/sub/mul/div on parametrised IEEE-754-style operands.
// Latency: 2 edges from accept to out_valid for add/sub/mul/specials, 2+DIV_ITER for div.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fpu_seq #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int DIV_ITER = MAN_W + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   opd1,
  input  logic [EXP_W+MAN_W:0]   opd2,
  input  logic [1:0]             op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   exp_overflow,
  output logic                   exp_underflow,
  output logic                   nan,
  output logic                   zero
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam int CW   = $clog2(DIV_ITER) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITER - 1);
  localparam logic [1:0] OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] ZERO_MAG = '0;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]            op_q, op_d;
  logic [MAN_W+1:0]      rem_q, rem_d;
  logic [MAN_W:0]        dvs_q, dvs_d;
  logic [DIV_ITER-1:0]   quo_q, quo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dsgn_q, dsgn_d;
  int                    dexp_q, dexp_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, nan_q, nan_d, zero_q, zero_d;

  // Operand fields, shared by all datapaths
  logic                  sa, sb, sbe, za, zb, ia, ib, na, nb;
  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      fa, fb;
  logic [MAN_W:0]        ma, mb;
  // Packed candidate results: {res, overflow, underflow, zero}
  logic [W+2:0]          exec_pk, div_pk;
  logic                  exec_nan, exec_div;
  logic [MAN_W+1:0]      rem_nx;
  logic [DIV_ITER-1:0]   quo_nx;

  // Saturate/flush a normalised value; e is the unbounded biased exponent.
  function automatic logic [W+2:0] pack(input logic s, input int e, input logic [MAN_W-1:0] m);
    logic [W+2:0] r;
    if (e >= EMAX)   r = {s, INF_MAG, 3'b100};
    else if (e <= 0) r = {s, ZERO_MAG, 3'b011};
    else             r = {s, e[EXP_W-1:0], m, 3'b000};
    return r;
  endfunction

  // Unpack, resolve specials and compute the single-cycle add/sub/mul result
  always_comb begin
    logic               swap, sh_s, sl_s, is_as;
    logic [EXP_W-1:0]   eh, el;
    logic [MAN_W:0]     mh, ml;
    logic [MAN_W+1:0]   al, sum, nrm, prod_hi;
    logic [2*MAN_W+1:0] prod;
    logic [W+2:0]       add_pk, mul_pk;
    int                 msb, ex;
    sa = a_q[W-1];  ea = a_q[W-2 -: EXP_W];  fa = a_q[MAN_W-1:0];
    sb = b_q[W-1];  eb = b_q[W-2 -: EXP_W];  fb = b_q[MAN_W-1:0];
    za = (ea == '0);             zb = (eb == '0);
    ia = (ea == '1) && (fa == '0); ib = (eb == '1) && (fb == '0);
    na = (ea == '1) && (fa != '0); nb = (eb == '1) && (fb != '0);
    ma = za ? '0 : {1'b1, fa};   mb = zb ? '0 : {1'b1, fb};
    is_as = (op_q[1] == 1'b0);
    sbe = sb ^ (op_q == OP_SUB);
    // add/sub: align the smaller magnitude under the larger, truncating shifted-out bits
    swap = {eb, fb} > {ea, fa};
    eh = swap ? eb : ea;   el = swap ? ea : eb;
    mh = swap ? mb : ma;   ml = swap ? ma : mb;
    sh_s = swap ? sbe : sa; sl_s = swap ? sa : sbe;
    al  = {1'b0, ml} >> (eh - el);
    sum = (sh_s == sl_s) ? ({1'b0, mh} + al) : ({1'b0, mh} - al);
    msb = 0;
    for (int i = 0; i <= MAN_W + 1; i++) if (sum[i]) msb = i;
    if (msb == MAN_W + 1) begin
      ex = int'(eh) + 1;           nrm = sum >> 1;
    end else begin
      ex = int'(eh) - (MAN_W - msb); nrm = sum << (MAN_W - msb);
    end
    // Exact zero sum is +0 unless both addends are -0
    if (sum == '0) add_pk = {sa & sbe, ZERO_MAG, 3'b001};
    else           add_pk = pack(sh_s, ex, MAN_W'(nrm));
    // mul: full-width significand product, keep the top MAN_W+2 bits
    prod    = {{(MAN_W+1){1'b0}}, ma} * {{(MAN_W+1){1'b0}}, mb};
    prod_hi = (MAN_W+2)'(prod >> MAN_W);
    if (prod_hi[MAN_W+1]) mul_pk = pack(sa ^ sb, int'(ea) + int'(eb) - BIAS + 1, MAN_W'(prod_hi >> 1));
    else                  mul_pk = pack(sa ^ sb, int'(ea) + int'(eb) - BIAS, MAN_W'(prod_hi));
    // Special-case priority; a finite non-special div goes to the iterative unit
    exec_pk = '0; exec_nan = 1'b0; exec_div = 1'b0;
    if (na || nb)                                                exec_nan = 1'b1;
    else if (is_as && ia && ib && (sa != sbe))                   exec_nan = 1'b1;
    else if (op_q == OP_MUL && ((za && ib) || (ia && zb)))       exec_nan = 1'b1;
    else if (op_q == OP_DIV && ((za && zb) || (ia && ib)))       exec_nan = 1'b1;
    else if (op_q == OP_DIV && zb)                               exec_pk = {sa ^ sb, INF_MAG, 3'b100};
    else if (op_q == OP_DIV && ib)                               exec_pk = {sa ^ sb, ZERO_MAG, 3'b001};
    else if (ia || ib)                                           exec_pk = {is_as ? (ia ? sa : sbe) : (sa ^ sb), INF_MAG, 3'b000};
    else if ((op_q == OP_MUL && (za || zb)) || (op_q == OP_DIV && za)) exec_pk = {sa ^ sb, ZERO_MAG, 3'b001};
    else if (is_as)                                              exec_pk = add_pk;
    else if (op_q == OP_MUL)                                     exec_pk = mul_pk;
    else                                                         exec_div = 1'b1;
    if (exec_nan) exec_pk = {QNAN, 3'b000};
  end

  // One restoring-division step plus normalise/pack of the quotient including this step's bit
  always_comb begin
    logic             ge;
    logic [MAN_W+1:0] rem_sub;
    ge      = (rem_q >= {1'b0, dvs_q});
    rem_sub = ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
    rem_nx  = rem_sub << 1;
    quo_nx  = {quo_q[DIV_ITER-2:0], ge};
    if (quo_nx[DIV_ITER-1]) div_pk = pack(dsgn_q, dexp_q, MAN_W'(quo_nx >> (DIV_ITER - 1 - MAN_W)));
    else                    div_pk = pack(dsgn_q, dexp_q - 1, MAN_W'(quo_nx >> (DIV_ITER - 2 - MAN_W)));
  end

  // FSM next-state and register updates
  always_comb begin
    state_d = state_q; a_d = a_q; b_d = b_q; op_d = op_q;
    rem_d = rem_q; dvs_d = dvs_q; quo_d = quo_q; cnt_d = cnt_q;
    dsgn_d = dsgn_q; dexp_d = dexp_q;
    res_d = res_q; ovf_d = ovf_q; unf_d = unf_q; nan_d = nan_q; zero_d = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = opd1; b_d = opd2; op_d = op; state_d = EXEC;
      end
      EXEC: if (exec_div) begin
        rem_d = {1'b0, ma}; dvs_d = mb; quo_d = '0; cnt_d = '0;
        dsgn_d = sa ^ sb; dexp_d = int'(ea) - int'(eb) + BIAS;
        state_d = DIV;
      end else begin
        {res_d, ovf_d, unf_d, zero_d} = exec_pk; nan_d = exec_nan;
        state_d = DONE;
      end
      DIV: begin
        rem_d = rem_nx; quo_d = quo_nx; cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          {res_d, ovf_d, unf_d, zero_d} = div_pk; nan_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; a_q <= '0; b_q <= '0; op_q <= '0;
      rem_q <= '0; dvs_q <= '0; quo_q <= '0; cnt_q <= '0;
      dsgn_q <= 1'b0; dexp_q <= 0;
      res_q <= '0; ovf_q <= 1'b0; unf_q <= 1'b0; nan_q <= 1'b0; zero_q <= 1'b0;
    end else begin
      state_q <= state_d; a_q <= a_d; b_q <= b_d; op_q <= op_d;
      rem_q <= rem_d; dvs_q <= dvs_d; quo_q <= quo_d; cnt_q <= cnt_d;
      dsgn_q <= dsgn_d; dexp_q <= dexp_d;
      res_q <= res_d; ovf_q <= ovf_d; unf_q <= unf_d; nan_q <= nan_d; zero_q <= zero_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign res           = res_q;
  assign exp_overflow  = ovf_q;
  assign exp_underflow = unf_q;
  assign nan           = nan_q;
  assign zero          = zero_q;

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: scoreboard bench for fpu_seq at single (8/23) and half (5/10) formats.
// Expected results are queued at issue time and checked at the output handshake.
// Also checks latency, stall hold, in_ready timing and async abort of a divide.
module tb_fpu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] opd1, opd2, res;
  logic [1:0]  op;
  logic        ovf, unf, nan, zero;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_opd1, h_opd2, h_res;
  logic [1:0]  h_op;
  logic        h_ovf, h_unf, h_nan, h_zero;

  fpu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opd1(opd1), .opd2(opd2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .exp_overflow(ovf), .exp_underflow(unf), .nan(nan), .zero(zero)
  );

  fpu_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .opd1(h_opd1), .opd2(h_opd2), .op(h_op), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .res(h_res), .exp_overflow(h_ovf), .exp_underflow(h_unf), .nan(h_nan), .zero(h_zero)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {overflow, underflow, nan, zero}
    int          id;
  } exp_t;

  exp_t sbq[$];
  exp_t hq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   op_id = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard pop on each output handshake, single-precision instance
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_has_entry", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk($sformatf("op%0d_res", e.id), 64'(res), 64'(e.res));
        chk($sformatf("op%0d_flags", e.id), 64'({ovf, unf, nan, zero}), 64'(e.flg));
      end
    end
  end

  // Scoreboard pop on each output handshake, half-precision instance
  always @(negedge clk) begin
    if (rst_n && h_out_valid && h_out_ready) begin
      chk("hsb_has_entry", 64'(hq.size() != 0), 64'd1);
      if (hq.size() != 0) begin
        exp_t e;
        e = hq.pop_front();
        chk($sformatf("hop%0d_res", e.id), 64'(h_res), 64'(e.res));
        chk($sformatf("hop%0d_flags", e.id), 64'({h_ovf, h_unf, h_nan, h_zero}), 64'(e.flg));
      end
    end
  end

  // Issue one op, check latency and in_ready, optionally stall the consumer
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input int lat, input int stall);
    exp_t e;
    int   n;
    op_id++;
    e.res = er; e.flg = ef; e.id = op_id;
    sbq.push_back(e);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk($sformatf("op%0d_idle_rdy", op_id), 64'(in_ready), 64'd1);
    op = o; opd1 = a; opd2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    // keep in_valid high with junk operands: the busy block must ignore them
    opd1 = $urandom; opd2 = $urandom; op = 2'($urandom);
    chk($sformatf("op%0d_busy_rdy", op_id), 64'(in_ready), 64'd0);
    n = 1;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk($sformatf("op%0d_lat", op_id), 64'(n), 64'(lat));
    for (int i = 0; i < stall; i++) begin
      chk($sformatf("op%0d_hold_res", op_id), 64'(res), 64'(er));
      chk($sformatf("op%0d_hold_rdy", op_id), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("op%0d_hold_vld", op_id), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk($sformatf("op%0d_post_vld", op_id), 64'(out_valid), 64'd0);
    chk($sformatf("op%0d_post_rdy", op_id), 64'(in_ready), 64'd1);
  endtask

  task automatic do_op_h(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [3:0] ef, input int lat);
    exp_t e;
    int   n;
    op_id++;
    e.res = 32'(er); e.flg = ef; e.id = op_id;
    hq.push_back(e);
    h_op = o; h_opd1 = a; h_opd2 = b; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    n = 1;
    while (!h_out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk($sformatf("hop%0d_lat", op_id), 64'(n), 64'(lat));
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_out_ready = 1'b0;
    chk($sformatf("hop%0d_post_rdy", op_id), 64'(h_in_ready), 64'd1);
  endtask

  // Start a divide, pull reset low mid-iteration and check nothing leaks out
  task automatic abort_div();
    int seen;
    op = 2'd3; opd1 = 32'h3F800000; opd2 = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_vld", 64'(out_valid), 64'd0);
    chk("abort_rdy", 64'(in_ready), 64'd1);
    chk("abort_res", 64'(res), 64'd0);
    chk("abort_flags", 64'({ovf, unf, nan, zero}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_rel_rdy", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("abort_no_stale", 64'(seen), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; opd1 = '0; opd2 = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_op = '0; h_opd1 = '0; h_opd2 = '0;
    #12;
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_flags", 64'({ovf, unf, nan, zero}), 64'd0);
    chk("rst_h_rdy", 64'(h_in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    //     op     opd1          opd2          result        flags lat stall
    do_op(2'd0, 32'h3FC00000, 32'h40100000, 32'h40700000, 4'h0, 2,  0);
    do_op(2'd2, 32'h40400000, 32'h40000000, 32'h40C00000, 4'h0, 2,  5);
    do_op(2'd3, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'h0, 27, 0);
    do_op(2'd3, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'h8, 2,  0);
    do_op(2'd3, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'h2, 2,  0);
    do_op(2'd2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h8, 2,  0);
    do_op(2'd2, 32'h00800000, 32'h00800000, 32'h00000000, 4'h5, 2,  0);
    do_op(2'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'h1, 2,  0);
    do_op(2'd1, 32'h00800000, 32'h00C00000, 32'h80000000, 4'h5, 2,  0);
    abort_div();
    do_op(2'd0, 32'h3F800000, 32'hBF400000, 32'h3E800000, 4'h0, 2,  0);
    do_op(2'd1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'h0, 2,  0);
    do_op(2'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 27, 2);
    do_op(2'd2, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0, 2,  0);
    do_op(2'd0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h2, 2,  0);
    do_op(2'd1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h2, 2,  0);
    do_op(2'd2, 32'h00000000, 32'hFF800000, 32'h7FC00000, 4'h2, 2,  0);
    do_op(2'd3, 32'h40000000, 32'hFF800000, 32'h80000000, 4'h1, 2,  0);
    do_op(2'd0, 32'h80000000, 32'h80000000, 32'h80000000, 4'h1, 2,  0);
    do_op(2'd0, 32'h3F800000, 32'h7F800000, 32'h7F800000, 4'h0, 2,  0);
    do_op(2'd0, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'h0, 2,  0);
    do_op(2'd3, 32'h00800000, 32'h7F000000, 32'h00000000, 4'h5, 27, 0);
    do_op(2'd3, 32'h7F000000, 32'h00800000, 32'h7F800000, 4'h8, 27, 0);
    do_op(2'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'h8, 2,  0);
    do_op(2'd2, 32'h00000000, 32'hBF800000, 32'h80000000, 4'h1, 2,  0);
    do_op(2'd3, 32'h00000000, 32'h40A00000, 32'h00000000, 4'h1, 2,  0);

    do_op_h(2'd0, 16'h3C00, 16'h4000, 16'h4200, 4'h0, 2);
    do_op_h(2'd3, 16'h3C00, 16'h4000, 16'h3800, 4'h0, 14);

    repeat (2) @(posedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("hsb_empty", 64'(hq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a hung handshake outside the bounded loops
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
